// File: rtl/diag_chain_sequencer.sv
// Sequences one diagnostic run: clear the loop chains, fill them with N compare rows,
// recirculate once while writing each row to eNVM, then latch the fault summaries.
module diag_chain_sequencer #(
  parameter int SYSTOLIC_SIZE = 8,
  parameter int ADDR_WIDTH    = $clog2(SYSTOLIC_SIZE),
  parameter int CNT_WIDTH     = $clog2(SYSTOLIC_SIZE*SYSTOLIC_SIZE+1)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  output logic [ADDR_WIDTH-1:0]    row_addr,
  input  logic [SYSTOLIC_SIZE-1:0] pe_row_data,
  output logic                     chain_clr_n,
  output logic                     chain_start_en,
  output logic [SYSTOLIC_SIZE-1:0] chain_col_inputs,
  input  logic [SYSTOLIC_SIZE-1:0] chain_single_pe,
  input  logic [SYSTOLIC_SIZE-1:0] chain_col_fault,
  input  logic [SYSTOLIC_SIZE-1:0] chain_row_fault,
  output logic                     envm_wr_en,
  output logic [ADDR_WIDTH-1:0]    envm_addr,
  output logic [SYSTOLIC_SIZE-1:0] envm_wdata,
  input  logic                     envm_ready,
  output logic                     busy,
  output logic                     done,
  output logic [SYSTOLIC_SIZE-1:0] col_fault_vec,
  output logic [SYSTOLIC_SIZE-1:0] row_fault_vec,
  output logic [CNT_WIDTH-1:0]     fault_count
);

  typedef enum logic [2:0] {IDLE, CLEAR, FILL, DUMP, SUMMARY, DONE} state_t;

  localparam logic [ADDR_WIDTH-1:0] K_LAST = ADDR_WIDTH'(SYSTOLIC_SIZE - 1);
  localparam logic [CNT_WIDTH-1:0]  CNT_MAX = '1;

  state_t                  state, state_nxt;
  logic [ADDR_WIDTH-1:0]   k;
  logic                    accept;
  logic [CNT_WIDTH-1:0]    row_pop;
  logic [CNT_WIDTH:0]      sum_wide;

  function automatic logic [CNT_WIDTH-1:0] popcount(input logic [SYSTOLIC_SIZE-1:0] v);
    logic [CNT_WIDTH-1:0] c;
    c = '0;
    for (int i = 0; i < SYSTOLIC_SIZE; i++) c = c + CNT_WIDTH'(v[i]);
    return c;
  endfunction

  assign accept   = (state == DUMP) && envm_ready;
  assign row_pop  = popcount(chain_single_pe);
  assign sum_wide = {1'b0, fault_count} + {1'b0, row_pop};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = CLEAR;
      CLEAR:   state_nxt = FILL;
      FILL:    if (k == K_LAST) state_nxt = DUMP;
      DUMP:    if (accept && (k == K_LAST)) state_nxt = SUMMARY;
      SUMMARY: state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    row_addr         = '0;
    chain_start_en   = 1'b0;
    chain_col_inputs = '0;
    envm_wr_en       = 1'b0;
    envm_addr        = '0;
    envm_wdata       = '0;
    busy             = (state != IDLE);
    done             = (state == DONE);
    case (state)
      FILL: begin
        row_addr         = k;
        chain_col_inputs = pe_row_data;
        chain_start_en   = 1'b1;
      end
      DUMP: begin
        envm_wr_en     = 1'b1;
        envm_addr      = k;
        envm_wdata     = chain_single_pe;
        // chains shift only on an accepted write so they stay aligned with k
        chain_start_en = envm_ready;
      end
      default: ;
    endcase
  end

  // Registered so the chain clear is glitch-free; low for exactly the CLEAR cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) chain_clr_n <= 1'b0;
    else        chain_clr_n <= (state_nxt != CLEAR);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k <= '0;
    end else begin
      case (state)
        FILL:    k <= (k == K_LAST) ? '0 : k + 1'b1;
        DUMP:    if (accept) k <= (k == K_LAST) ? '0 : k + 1'b1;
        default: k <= '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fault_count   <= '0;
      col_fault_vec <= '0;
      row_fault_vec <= '0;
    end else begin
      if (state == IDLE && start) fault_count <= '0;
      else if (accept)            fault_count <= sum_wide[CNT_WIDTH] ? CNT_MAX : sum_wide[CNT_WIDTH-1:0];
      if (state == SUMMARY) begin
        col_fault_vec <= chain_col_fault;
        row_fault_vec <= chain_row_fault;
      end
    end
  end

endmodule

// File: tb/tb_diag_chain_sequencer.sv
// Directed bench for diag_chain_sequencer with a behavioural loop-chain model and
// a write scoreboard checked against row contents and summaries derived from the rows.
module tb_diag_chain_sequencer;
  localparam int N  = 8;
  localparam int AW = 3;
  localparam int CW = 7;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] row_addr;
  logic [N-1:0]  pe_row_data;
  logic          chain_clr_n, chain_start_en;
  logic [N-1:0]  chain_col_inputs, chain_single_pe, chain_col_fault, chain_row_fault;
  logic          envm_wr_en;
  logic [AW-1:0] envm_addr;
  logic [N-1:0]  envm_wdata;
  logic          envm_ready = 1'b1;
  logic          busy, done;
  logic [N-1:0]  col_fault_vec, row_fault_vec;
  logic [CW-1:0] fault_count;

  diag_chain_sequencer #(.SYSTOLIC_SIZE(N)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .row_addr(row_addr), .pe_row_data(pe_row_data),
    .chain_clr_n(chain_clr_n), .chain_start_en(chain_start_en), .chain_col_inputs(chain_col_inputs),
    .chain_single_pe(chain_single_pe), .chain_col_fault(chain_col_fault), .chain_row_fault(chain_row_fault),
    .envm_wr_en(envm_wr_en), .envm_addr(envm_addr), .envm_wdata(envm_wdata), .envm_ready(envm_ready),
    .busy(busy), .done(done), .col_fault_vec(col_fault_vec), .row_fault_vec(row_fault_vec),
    .fault_count(fault_count)
  );

  always #5 clk = ~clk;

  logic [N-1:0] rows [N];
  assign pe_row_data = rows[row_addr];

  // Loop-chain model: stage 0 takes new column input OR the recirculated tail.
  logic [N-1:0] stg [N];
  always @(posedge clk or negedge chain_clr_n) begin
    if (!chain_clr_n) begin
      for (int i = 0; i < N; i++) stg[i] <= '0;
    end else if (chain_start_en) begin
      stg[0] <= chain_col_inputs | stg[N-1];
      for (int i = 1; i < N; i++) stg[i] <= stg[i-1];
    end
  end
  assign chain_single_pe = stg[N-1];
  assign chain_col_fault = stg[0] & stg[1] & stg[2];
  always_comb begin
    chain_row_fault = '0;
    for (int i = 0; i < N; i++) chain_row_fault[i] = |(stg[i] & (stg[i] >> 1) & (stg[i] >> 2));
  end

  int pass_cnt = 0;
  int total = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v) pass_cnt++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
  endtask

  typedef struct packed {logic [AW-1:0] a; logic [N-1:0] d;} wr_t;
  wr_t sb [$];
  int  wr_cnt = 0;
  logic bp_on = 1'b0;
  int   ph = 0;

  // Back-pressure pattern 1,0,0,1,0,0,...
  always @(posedge clk) begin
    #1;
    if (bp_on) begin
      envm_ready = (ph % 3 == 0);
      ph++;
    end else begin
      envm_ready = 1'b1;
      ph = 0;
    end
  end

  logic          hold_v = 1'b0;
  logic [AW-1:0] hold_a;
  logic [N-1:0]  hold_d;

  always @(negedge clk) begin
    if (!rst_n) begin
      hold_v = 1'b0;
    end else begin
      if (hold_v) begin
        chk("stall_addr_stable", 32'(envm_addr), 32'(hold_a));
        chk("stall_data_stable", 32'(envm_wdata), 32'(hold_d));
        hold_v = 1'b0;
      end
      if (envm_wr_en && envm_ready) begin
        wr_t e;
        if (sb.size() == 0) begin
          chk("unexpected_write", 32'(envm_addr), 32'hFFFF);
        end else begin
          e = sb.pop_front();
          chk("wr_addr", 32'(envm_addr), 32'(e.a));
          chk("wr_data", 32'(envm_wdata), 32'(e.d));
        end
        wr_cnt++;
      end else if (envm_wr_en) begin
        chk("stall_no_shift", 32'(chain_start_en), 32'd0);
        hold_v = 1'b1;
        hold_a = envm_addr;
        hold_d = envm_wdata;
      end
    end
  end

  task automatic load_rows(input logic [N-1:0] fill, input int r_sel, input logic [N-1:0] v_sel,
                           input int r_sel2, input logic [N-1:0] v_sel2);
    for (int r = 0; r < N; r++) rows[r] = fill;
    if (r_sel >= 0)  rows[r_sel] = v_sel;
    if (r_sel2 >= 0) rows[r_sel2] = v_sel2;
  endtask

  task automatic run(input string name, input logic bp);
    int c;
    int pc;
    logic [N-1:0] ecol, erow, rv;
    pc = 0;
    for (int r = 0; r < N; r++) begin
      sb.push_back(wr_t'{a: AW'(r), d: rows[r]});
      pc += $countones(rows[r]);
    end
    ecol = rows[N-1] & rows[N-2] & rows[N-3];
    for (int i = 0; i < N; i++) begin
      rv = rows[N-1-i];
      erow[i] = |(rv & (rv >> 1) & (rv >> 2));
    end
    bp_on = bp;
    @(negedge clk);
    start = 1'b1;
    c = 0;
    while (1) begin
      @(posedge clk);
      #1;
      if (c == 0) start = 1'b0;
      c++;
      if (done) break;
      if (c > 300) begin
        chk({name, "_done_timeout"}, 32'(c), 32'd0);
        break;
      end
    end
    bp_on = 1'b0;
    if (!bp) chk({name, "_latency"}, 32'(c), 32'(2*N+3));
    chk({name, "_busy_in_done"}, 32'(busy), 32'd1);
    chk({name, "_fault_count"}, 32'(fault_count), 32'(pc));
    chk({name, "_col_fault"}, 32'(col_fault_vec), 32'(ecol));
    chk({name, "_row_fault"}, 32'(row_fault_vec), 32'(erow));
    chk({name, "_writes_left"}, 32'(sb.size()), 32'd0);
    @(posedge clk);
    #1;
    chk({name, "_idle_busy"}, 32'(busy), 32'd0);
    chk({name, "_idle_done"}, 32'(done), 32'd0);
  endtask

  initial begin
    int c;
    for (int r = 0; r < N; r++) rows[r] = '0;
    #12;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_clr_n", 32'(chain_clr_n), 32'd0);
    chk("rst_wr_en", 32'(envm_wr_en), 32'd0);
    chk("rst_count", 32'(fault_count), 32'd0);
    chk("rst_col_vec", 32'(col_fault_vec), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_clr_n", 32'(chain_clr_n), 32'd1);

    load_rows('0, -1, '0, -1, '0);
    run("zero", 1'b0);
    load_rows('0, 3, 8'h04, -1, '0);
    run("single", 1'b0);
    load_rows('0, 5, 8'h01, 6, 8'h01);
    rows[7] = 8'h01;
    run("column", 1'b0);
    load_rows('0, 2, 8'hE0, -1, '0);
    run("row", 1'b0);
    load_rows('0, 2, 8'hE0, -1, '0);
    rows[5] = 8'h01; rows[6] = 8'h01; rows[7] = 8'h01; rows[3] = 8'h04;
    run("bp", 1'b1);

    // Abort mid-dump after three accepted writes.
    load_rows(8'hFF, -1, '0, -1, '0);
    for (int r = 0; r < N; r++) sb.push_back(wr_t'{a: AW'(r), d: rows[r]});
    wr_cnt = 0;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    c = 0;
    while (wr_cnt < 3 && c < 100) begin
      @(posedge clk);
      #1;
      c++;
    end
    chk("abort_reached_dump", 32'(envm_wr_en), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_clr_n", 32'(chain_clr_n), 32'd0);
    chk("abort_wr_en", 32'(envm_wr_en), 32'd0);
    chk("abort_count", 32'(fault_count), 32'd0);
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    load_rows('0, -1, '0, -1, '0);
    run("after_abort", 1'b0);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
